// File: rtl/afe_config_pkg.sv
// afe_config_pkg: opcodes, ROM word layout and sequencer states shared by the AFE configuration blocks
package afe_config_pkg;
  localparam logic [3:0] OP_SEND = 4'h0;
  localparam logic [3:0] OP_WAIT = 4'h1;
  localparam logic [3:0] OP_END = 4'hF;
  localparam int OPCODE_MSB = 23;
  localparam int OPCODE_LSB = 20;
  localparam int PAYLOAD_WIDTH = 20;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, START, WAIT_DONE, DELAY, NEXT, DONE, ERROR} state_t;
endpackage

// File: rtl/afe_command_sequencer_if.sv
// afe_command_sequencer_if: ROM read port plus serial-out transaction handshake
interface afe_command_sequencer_if #(parameter int ADDR_WIDTH = 8);
  import afe_config_pkg::*;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [OPCODE_MSB:0] rom_command;
  logic [PAYLOAD_WIDTH-1:0] afe_command;
  logic start_transaction;
  logic transaction_done;
  modport master(output rom_address, afe_command, start_transaction, input rom_command, transaction_done);
  modport slave(input rom_address, afe_command, start_transaction, output rom_command, transaction_done);
endinterface

// File: rtl/afe_seq_counter.sv
// afe_seq_counter: loadable down-counter that stops at zero and flags it
module afe_seq_counter #(parameter int WIDTH = 20) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             terminal
);
  logic [WIDTH-1:0] count;
  assign terminal = count == '0;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (en && !terminal) count <= count - 1'b1;
  end
endmodule

// File: rtl/afe_command_sequencer.sv
// afe_command_sequencer: walks the command ROM, issues SEND transactions, executes WAITs, flags END or faults
module afe_command_sequencer
  import afe_config_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_LATENCY = 1,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  afe_command_sequencer_if.master  bus,
  output logic                     command_transactions_done,
  output logic                     error,
  output logic                     busy
);
  localparam int TW = $clog2(DONE_TIMEOUT);
  localparam int LW = ROM_LATENCY > 1 ? $clog2(ROM_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};
  state_t state, state_next;
  logic [LW-1:0] fetch_count;
  logic [3:0] opcode;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic last_fetch, delay_zero, timeout_zero;
  assign opcode = bus.rom_command[OPCODE_MSB:OPCODE_LSB];
  assign payload = bus.rom_command[PAYLOAD_WIDTH-1:0];
  assign last_fetch = fetch_count == LW'(ROM_LATENCY - 1);
  // Both counters stop at zero, so they are loaded with (length - 1) to span exactly length clocks
  afe_seq_counter #(.WIDTH(PAYLOAD_WIDTH)) delay_counter (
    .clk(clk), .rst(reset), .load(state == DECODE), .en(state == DELAY),
    .value(payload - 1'b1), .terminal(delay_zero)
  );
  afe_seq_counter #(.WIDTH(TW)) timeout_counter (
    .clk(clk), .rst(reset), .load(state == START), .en(state == WAIT_DONE),
    .value(TW'(DONE_TIMEOUT - 1)), .terminal(timeout_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = state;
    bus.start_transaction = 1'b0;
    command_transactions_done = 1'b0;
    error = 1'b0;
    busy = !(state inside {IDLE, DONE, ERROR});
    case (state)
      IDLE: state_next = enable ? FETCH : IDLE;
      FETCH: state_next = last_fetch ? DECODE : FETCH;
      DECODE: state_next = opcode == OP_SEND ? START :
                           opcode == OP_WAIT ? (payload == '0 ? NEXT : DELAY) :
                           opcode == OP_END ? DONE : ERROR;
      START: begin
        bus.start_transaction = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: state_next = bus.transaction_done ? NEXT : timeout_zero ? ERROR : WAIT_DONE;
      DELAY: state_next = delay_zero ? NEXT : DELAY;
      NEXT: state_next = bus.rom_address == LAST ? ERROR : FETCH;
      DONE: command_transactions_done = 1'b1;
      ERROR: error = 1'b1;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_address <= '0;
      bus.afe_command <= '0;
      fetch_count <= '0;
    end else begin
      fetch_count <= (state == FETCH && !last_fetch) ? fetch_count + 1'b1 : '0;
      if (state == NEXT && bus.rom_address != LAST) bus.rom_address <= bus.rom_address + 1'b1;
      if (state == DECODE && opcode == OP_SEND) bus.afe_command <= payload;
    end
  end
endmodule

// File: tb/tb_afe_command_sequencer.sv
// tb_afe_command_sequencer: list-walk timing model checked every cycle plus literal pins per scenario
module tb_afe_command_sequencer;
  localparam int L = 1;
  localparam int TO = 4096;
  logic clk = 0, reset = 1, enable = 0;
  logic ctd, err, busy;
  afe_command_sequencer_if #(.ADDR_WIDTH(8)) bus();
  afe_command_sequencer #(.ADDR_WIDTH(8), .ROM_LATENCY(L), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .command_transactions_done(ctd), .error(err), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [23:0] rom [256];
  always @(posedge clk) bus.rom_command <= rom[bus.rom_address];
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask
  // Serial-out stand-in: done pulse D clocks after each start, optional spurious done during START
  int resp_cnt = 0, done_delay = 10;
  bit resp_on = 1, dup_on = 0;
  initial begin
    bus.transaction_done = 0;
    forever begin
      @(negedge clk);
      bus.transaction_done = 0;
      if (resp_cnt == 1) bus.transaction_done = 1;
      if (resp_cnt > 0) resp_cnt--;
      if (bus.start_transaction && resp_on && !reset) begin
        resp_cnt = done_delay;
        if (dup_on) bus.transaction_done = 1;
      end
    end
  end
  int exp_start[int];
  logic [19:0] exp_afe[int];
  int exp_en, exp_end;
  bit exp_err, check_on = 0;
  // Walk the list: each word costs L fetch + 1 decode; SEND adds start + response + next, WAIT adds N + next
  task automatic build_model(input int e, input int d_lat, input bit resp);
    int t, dec, s, d, nxt, a;
    logic [23:0] w;
    exp_start.delete();
    exp_afe.delete();
    exp_en = e;
    t = e;
    a = 0;
    while (1) begin
      w = rom[a];
      dec = t + L;
      nxt = 0;
      case (w[23:20])
        4'h0: begin
          s = dec + 1;
          d = resp ? s + d_lat : s + TO;
          exp_start[s] = 1;
          for (int c = s; c <= d + 1; c++) exp_afe[c] = w[19:0];
          if (!resp) begin
            exp_end = d + 1;
            exp_err = 1;
            return;
          end
          nxt = d + 1;
        end
        4'h1: nxt = dec + 1 + int'(w[19:0]);
        4'hF: begin
          exp_end = dec + 1;
          exp_err = 0;
          return;
        end
        default: begin
          exp_end = dec + 1;
          exp_err = 1;
          return;
        end
      endcase
      if (a == 255) begin
        exp_end = nxt + 1;
        exp_err = 1;
        return;
      end
      a++;
      t = nxt + 1;
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (check_on) begin
      chk("start_transaction", bus.start_transaction, exp_start.exists(cyc) ? 1 : 0);
      if (exp_afe.exists(cyc)) chk("afe_command", bus.afe_command, exp_afe[cyc]);
      chk("command_transactions_done", ctd, (!exp_err && cyc >= exp_end) ? 1 : 0);
      chk("error", err, (exp_err && cyc >= exp_end) ? 1 : 0);
      chk("busy", busy, (cyc >= exp_en && cyc < exp_end) ? 1 : 0);
    end
  end
  int c0, st_n, done_first, err_first;
  int st_cyc[$];
  logic [19:0] st_cmd[$];
  task automatic observe();
    if (bus.start_transaction) begin
      st_n++;
      st_cyc.push_back(cyc);
      st_cmd.push_back(bus.afe_command);
    end
    if (ctd && done_first < 0) done_first = cyc;
    if (err && err_first < 0) err_first = cyc;
  endtask
  task automatic arm(input int d_lat, input bit resp);
    c0 = cyc;
    build_model(c0 + 1, d_lat, resp);
    st_n = 0;
    done_first = -1;
    err_first = -1;
    st_cyc.delete();
    st_cmd.delete();
    check_on = 1;
  endtask
  task automatic start_run(input int d_lat, input bit resp, input bit dup);
    check_on = 0;
    enable = 0;
    reset = 1;
    resp_cnt = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    done_delay = d_lat;
    resp_on = resp;
    dup_on = dup;
    enable = 1;
    arm(d_lat, resp);
  endtask
  task automatic finish_run();
    while (cyc <= exp_end + 3) begin
      @(negedge clk);
      observe();
    end
    check_on = 0;
    enable = 0;
  endtask
  function automatic logic [31:0] q_at(input int i, input logic [31:0] q[$]);
    return i < q.size() ? q[i] : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] cyc_at(input int i);
    return i < st_cyc.size() ? 32'(st_cyc[i] - c0) : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] cmd_at(input int i);
    return i < st_cmd.size() ? 32'(st_cmd[i]) : 32'hdead_beef;
  endfunction
  task automatic set_rom3(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    for (int i = 0; i < 256; i++) rom[i] = 24'hF00000;
    rom[0] = a;
    rom[1] = b;
    rom[2] = c;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_afe_command", bus.afe_command, 0);
    chk("reset_rom_address", bus.rom_address, 0);
    chk("reset_start", bus.start_transaction, 0);
    chk("reset_flags", {ctd, err, busy}, 0);
    set_rom3({4'h0, 20'h00001}, {4'h0, 20'h0A5A5}, {4'hF, 20'h0});
    start_run(10, 1, 0);
    finish_run();
    chk("t1_starts", st_n, 2);
    chk("t1_first_start_lat", cyc_at(0), 3);
    chk("t1_second_start_lat", cyc_at(1), 17);
    chk("t1_cmd0", cmd_at(0), 32'h00001);
    chk("t1_cmd1", cmd_at(1), 32'h0A5A5);
    chk("t1_done_lat", done_first - c0, 31);
    chk("t1_no_error", err_first, -1);
    set_rom3({4'h1, 20'd5}, {4'h0, 20'h12345}, {4'hF, 20'h0});
    start_run(10, 1, 0);
    finish_run();
    chk("t2_starts", st_n, 1);
    chk("t2_start_lat", cyc_at(0), 11);
    chk("t2_cmd", cmd_at(0), 32'h12345);
    chk("t2_done_lat", done_first - c0, 25);
    set_rom3({4'h0, 20'h00077}, {4'h0, 20'h00088}, {4'hF, 20'h0});
    start_run(10, 0, 0);
    finish_run();
    chk("t3_starts", st_n, 1);
    chk("t3_error_lat", err_first - c0, 4100);
    chk("t3_no_done", done_first, -1);
    set_rom3({4'h7, 20'h00011}, {4'h0, 20'h00022}, {4'hF, 20'h0});
    start_run(10, 1, 0);
    finish_run();
    chk("t4_starts", st_n, 0);
    chk("t4_error_lat", err_first - c0, 3);
    for (int i = 0; i < 256; i++) rom[i] = {4'h0, 20'(i)};
    start_run(2, 1, 0);
    finish_run();
    chk("t5_starts", st_n, 256);
    chk("t5_last_cmd", cmd_at(255), 255);
    chk("t5_error", err, 1);
    chk("t5_no_done", done_first, -1);
    chk("t5_rom_address", bus.rom_address, 255);
    set_rom3({4'h0, 20'h00001}, {4'h0, 20'h0A5A5}, {4'hF, 20'h0});
    start_run(10, 1, 0);
    for (int g = 0; g < 200 && st_n < 2; g++) begin
      @(negedge clk);
      observe();
    end
    chk("t6_reached_second_start", st_n, 2);
    @(negedge clk);
    check_on = 0;
    reset = 1;
    @(negedge clk);
    chk("t6_reset_afe_command", bus.afe_command, 0);
    chk("t6_reset_rom_address", bus.rom_address, 0);
    chk("t6_reset_outputs", {bus.start_transaction, ctd, err, busy}, 0);
    reset = 0;
    resp_cnt = 0;
    arm(10, 1);
    finish_run();
    chk("t6_restart_starts", st_n, 2);
    chk("t6_restart_first_lat", cyc_at(0), 3);
    chk("t6_restart_cmd0", cmd_at(0), 32'h00001);
    chk("t6_restart_done_lat", done_first - c0, 31);
    start_run(10, 1, 1);
    finish_run();
    chk("t7_starts", st_n, 2);
    chk("t7_second_start_lat", cyc_at(1), 17);
    chk("t7_done_lat", done_first - c0, 31);
    chk("t7_no_error", err_first, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
